// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble add sequencer.
//   NIB_W   : width of one processed digit (bits)
//   state_t : sequencer states
package nibble_add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// Request/response bundle for the nibble add sequencer.
//   req0_*/req1_* : two requesters, valid/ready handshake with operands a, b
//   rsp_*         : single result channel, valid/ready with sum, carry, id
// Modports: master = requesters + consumer side, slave = sequencer side.
interface nibble_add_sequencer_if
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIB_W * NIBBLES;

  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;

  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_a, req1_b, input req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id, output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_a, req1_b, output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id, input rsp_ready
  );

endinterface

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder used once per ADD cycle by the sequencer.
//   a, b  : nibble operands
//   c_in  : carry from the previous nibble
//   sum   : nibble result
//   c_out : carry into the next nibble
module nibble_adder
  import nibble_add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in,
  output logic [NIB_W-1:0] sum,
  output logic             c_out
);

  logic cy;

  always_comb begin
    cy  = c_in;
    sum = '0;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Two-requester, round-robin arbitrated serial adder. A granted request is
// captured, then added one nibble per cycle through a single nibble_adder;
// the result is held on the response channel until consumed.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : nibble_add_sequencer_if slave modport (requests + response)
//
// state | meaning
// IDLE  | waiting for a request; ready asserted to the granted requester
// ADD   | adding nibble k of the captured operands each cycle
// DONE  | result valid, held until rsp_ready
module nibble_add_sequencer
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  nibble_add_sequencer_if.slave        bus
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][NIB_W-1:0] word_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  word_t         a_q, a_d;
  word_t         b_q, b_d;
  word_t         sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          id_q, id_d;
  logic [KW-1:0] k_q, k_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             ready0, ready1, rsp_valid;
  logic [NIB_W-1:0] add_sum;
  logic             add_cout;

  nibble_adder u_adder (
    .a     (a_q[k_q]),
    .b     (b_q[k_q]),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    id_d      = id_q;
    k_d       = k_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    rsp_valid = 1'b0;

    gnt_any = bus.req0_valid | bus.req1_valid;
    // Pointer only matters on contention; a lone valid always wins.
    gnt_id  = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;

    case (state_q)
      IDLE: begin
        if (!rst && gnt_any) begin
          ready0  = ~gnt_id;
          ready1  = gnt_id;
          a_d     = gnt_id ? bus.req1_a : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b : bus.req0_b;
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
          k_d     = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[k_q] = add_sum;
        carry_d    = add_cout;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        rsp_valid = ~rst;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      k_q     <= k_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = carry_q;
  assign bus.rsp_id     = id_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
module tb_nibble_add_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;
  logic seen;

  nibble_add_sequencer_if #(.NIBBLES(4)) bus ();

  nibble_add_sequencer #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!bus.rsp_valid && edges < 20) begin
      tick();
      edges++;
    end
    chk("rsp_timeout", 32'(edges < 20), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'h0;
    bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0;
    bus.req1_a = 16'h0;
    bus.req1_b = 16'h0;
    bus.rsp_ready = 1'b0;

    // Reset: readys and rsp_valid held low even with a valid pending
    tick();
    tick();
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rst_sum", 32'(bus.rsp_sum), 32'h0);
    chk("rst_cout", 32'(bus.rsp_cout), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Requester 0 only: 0x1234 + 0x1111
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'h1234;
    bus.req0_b = 16'h1111;
    #1;
    chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
    chk("t1_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    chk("t1_add_ready0", 32'(bus.req0_ready), 32'd0);
    wait_rsp(n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_sum", 32'(bus.rsp_sum), 32'h2345);
    chk("t1_cout", 32'(bus.rsp_cout), 32'd0);
    chk("t1_id", 32'(bus.rsp_id), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t1_consumed", 32'(bus.rsp_valid), 32'd0);

    // Requester 1 only: 0xFFFF + 0x0001, full carry ripple
    bus.req1_valid = 1'b1;
    bus.req1_a = 16'hFFFF;
    bus.req1_b = 16'h0001;
    #1;
    chk("t2_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(n);
    chk("t2_latency", 32'(n), 32'd4);
    chk("t2_sum", 32'(bus.rsp_sum), 32'h0000);
    chk("t2_cout", 32'(bus.rsp_cout), 32'd1);
    chk("t2_id", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t2_consumed", 32'(bus.rsp_valid), 32'd0);

    // Both valid continuously: round-robin 0, 1, 0
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'h0F0F;
    bus.req0_b = 16'h00F1;
    bus.req1_valid = 1'b1;
    bus.req1_a = 16'h0F0F;
    bus.req1_b = 16'h00F1;
    wait_rsp(n);
    chk("t3_r0_id", 32'(bus.rsp_id), 32'd0);
    chk("t3_r0_sum", 32'(bus.rsp_sum), 32'h1000);
    chk("t3_r0_cout", 32'(bus.rsp_cout), 32'd0);
    chk("t3_r0_noacc", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    tick();
    chk("t3_r0_gone", 32'(bus.rsp_valid), 32'd0);
    wait_rsp(n);
    chk("t3_r1_id", 32'(bus.rsp_id), 32'd1);
    chk("t3_r1_sum", 32'(bus.rsp_sum), 32'h1000);
    chk("t3_r1_cout", 32'(bus.rsp_cout), 32'd0);
    tick();
    wait_rsp(n);
    chk("t3_r2_id", 32'(bus.rsp_id), 32'd0);
    chk("t3_r2_sum", 32'(bus.rsp_sum), 32'h1000);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("t3_idle", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: 0xA5A5 + 0x6B6B held for 3 cycles with req1 pending
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'hA5A5;
    bus.req0_b = 16'h6B6B;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a = 16'h0001;
    bus.req1_b = 16'h0002;
    wait_rsp(n);
    for (int i = 0; i < 3; i++) begin
      chk("t4_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t4_sum", 32'(bus.rsp_sum), 32'h1110);
      chk("t4_cout", 32'(bus.rsp_cout), 32'd1);
      chk("t4_id", 32'(bus.rsp_id), 32'd0);
      chk("t4_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_noacc_done", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    chk("t4_released", 32'(bus.rsp_valid), 32'd0);
    chk("t4_next_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    wait_rsp(n);
    chk("t4b_sum", 32'(bus.rsp_sum), 32'h0003);
    chk("t4b_id", 32'(bus.rsp_id), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();

    // Reset in the second ADD cycle discards the operation
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'h1111;
    bus.req0_b = 16'h2222;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_sum", 32'(bus.rsp_sum), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    chk("t5_no_rsp", 32'(seen), 32'd0);
    // Pointer back at requester 0 after reset, so contention grants 0
    bus.req0_valid = 1'b1;
    bus.req0_a = 16'h8000;
    bus.req0_b = 16'h8000;
    bus.req1_valid = 1'b1;
    bus.req1_a = 16'h8000;
    bus.req1_b = 16'h8000;
    #1;
    chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(n);
    chk("t5_latency", 32'(n), 32'd4);
    chk("t5_sum", 32'(bus.rsp_sum), 32'h0000);
    chk("t5_cout", 32'(bus.rsp_cout), 32'd1);
    chk("t5_id", 32'(bus.rsp_id), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_sequencer.md
NIBBLE_ADD_SEQUENCER -- requirements
Module: nibble_add_sequencer

Interface
REQ-001 Parameter NIBBLES SHALL default to 4; it sets the operand width W = 4*NIBBLES bits, processed one nibble per cycle.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 has operands.
REQ-005 req0_a, req0_b  in  W  requester 0 operands.
REQ-006 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  SHALL match req0_* in direction and width, for requester 1.
REQ-008 rsp_valid  out  1  result available.
REQ-009 rsp_ready  in  1  consumer accepts the result.
REQ-010 rsp_sum  out  W  A+B modulo 2^W.
REQ-011 rsp_cout  out  1  carry out of the MSB nibble.
REQ-012 rsp_id  out  1  index of the granted requester.

Function
REQ-013 The FSM SHALL have three states, IDLE, ADD and DONE, with transitions IDLE->ADD on grant, ADD->DONE after NIBBLES cycles, and DONE->IDLE on rsp_valid&&rsp_ready.
REQ-014 reqX_ready SHALL be high only in IDLE, only for the granted requester, and the handshake SHALL be reqX_valid&&reqX_ready.
REQ-015 Arbitration SHALL be round-robin:
- If only one requester is valid, it SHALL be granted.
- If both are valid, the requester selected by a 1-bit priority pointer SHALL be granted.
- After each grant, the pointer SHALL point to the non-granted requester.
REQ-016 On the accepting edge the block SHALL capture both operands and the requester id, clear the nibble index to 0 and clear the carry register to 0.
REQ-017 In ADD, each cycle SHALL add nibble k of A and B plus the carry register, write sum nibble k, store the carry-out and increment k.
REQ-018 rsp_valid SHALL first be high exactly NIBBLES rising edges after the accepting edge (4 for the default).
REQ-019 In DONE, rsp_valid SHALL stay high and rsp_sum, rsp_cout and rsp_id SHALL stay stable until rsp_ready is high.
REQ-020 The sequencer SHALL NOT accept a new request in the same cycle that the response completes; the earliest next accept is the cycle after DONE->IDLE.
REQ-021 Requesters SHALL hold valid and operands stable until ready; a valid that drops before grant SHALL NOT be granted.
REQ-022 The nibble index and the carry SHALL NOT leak between operations, and operand wrap-around SHALL be reported only through rsp_cout.
REQ-023 rsp_valid SHALL be low in IDLE and ADD.

Reset
REQ-024 While rst is high on a clock edge, the block SHALL enter IDLE, set the pointer to requester 0, and clear the nibble index, the carry, rsp_sum, rsp_cout and rsp_id to 0.
REQ-025 During reset, rsp_valid, req0_ready and req1_ready SHALL be 0.
REQ-026 Reset during ADD or DONE SHALL discard the operation in progress; no response SHALL be emitted for it.

Structure
REQ-027 Package nibble_add_seq_pkg SHALL hold the state enum (IDLE, ADD, DONE) and the nibble width constant (4).
REQ-028 One sub-module, nibble_adder, SHALL be used: a 4-bit ripple adder with inputs a[3:0], b[3:0], c_in and outputs sum[3:0], c_out, instantiated once and reused every ADD cycle.
REQ-029 Operands and the result SHALL be held in internal registers; no combinational path SHALL exist from req*_a or req*_b to rsp_*.

Verification (NIBBLES=4)
REQ-030 Requester 0 only, 0x1234+0x1111 -> rsp_valid 4 edges after accept; sum 0x2345, cout 0, id 0.
REQ-031 Requester 1 only, 0xFFFF+0x0001 -> sum 0x0000, cout 1, id 1 (carry ripples through all nibbles).
REQ-032 Both requesters valid continuously, operands 0x0F0F+0x00F1 on both, rsp_ready high -> responses with id 0 then id 1 then id 0; each sum 0x1000, cout 0.
REQ-033 rsp_ready held low 3 cycles in DONE -> rsp_sum, rsp_cout and rsp_id stable; both readys 0; no new accept.
REQ-034 rst pulsed one cycle at the second ADD cycle -> no response; then 0x8000+0x8000 -> sum 0x0000, cout 1, id 0.
